id_ex_reg: RTL

- Decode-to-execute pipeline register of the 5-stage RV32I core.
- Captures the sign-extended immediate (ImmExtD) from the immediate extender, along with:
  - register-file read data,
  - PC values,
  - register indices,
  - decoded control bundle.
- Presents these to the execute stage one cycle later.
- Implements stall (hold) and flush (bubble insertion) driven by the hazard unit, plus a valid bit so squashed slots execute as NOPs.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/pipe_reg.sv | 31 +++
 rtl/id_ex_reg.sv | 123 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I core types: control bundle, NOP constant, widths
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  // Decoded control bundle carried down the pipeline.
  typedef struct packed {
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic       MemWrite;
    logic       Jump;
    logic       Branch;
    logic [3:0] ALUControl;
    logic       ALUSrc;
  } ctrl_t;

  localparam int    CTRL_W   = $bits(ctrl_t);
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - generic pipeline register with enable, synchronous clear, async reset
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset, q -> 0
//   en   load d when high (ignored while clr is high)
//   clr  synchronous clear to 0, wins over en
//   d    next value
//   q    registered value
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - decode-to-execute pipeline register with stall, flush and valid gating
//
// Optional feature macro: ID_EX_PERF_EN (bubble / stall performance counters).
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   StallE, FlushE      hazard-unit hold / bubble-insert requests (flush wins)
//   ValidD              decode slot holds a real instruction
//   PCD .. funct3D      decode-stage datapath fields
//   CtrlD               decoded control bundle
//   ValidE .. CtrlE     registered execute-stage copies
//   BubbleCntE          bubbles inserted (0 when ID_EX_PERF_EN is undefined)
//   StallCntE           stall cycles     (0 when ID_EX_PERF_EN is undefined)
module id_ex_reg
  import riscv_pkg::*;
#(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              ValidD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [2:0]        funct3D,
  input  ctrl_t             CtrlD,
  output logic              ValidE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
  output logic [2:0]        funct3E,
  output ctrl_t             CtrlE,
  output logic [31:0]       BubbleCntE,
  output logic [31:0]       StallCntE
);

  localparam int DATA_W = 5 * XLEN + 3 * REG_AW + 3;

  logic              en;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;
  ctrl_t             ctrl_d;
  ctrl_t             ctrl_q;

  assign en = ~StallE;

  // Datapath fields travel ungated; an X on ImmExtD only ever lands in ImmExtE.
  assign data_d = {PCD, PCPlus4D, RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD, funct3D};

  // Control is squashed to NOP for invalid slots so a bubble can never write
  // state, regardless of what the decoder produced. It depends only on ValidD.
  assign ctrl_d = ValidD ? CtrlD : CTRL_NOP;

  pipe_reg #(.W(DATA_W)) u_data (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (FlushE),
    .d   (data_d),
    .q   (data_q)
  );

  pipe_reg #(.W(CTRL_W)) u_ctrl (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (FlushE),
    .d   (ctrl_d),
    .q   (ctrl_q)
  );

  pipe_reg #(.W(1)) u_valid (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (FlushE),
    .d   (ValidD),
    .q   (ValidE)
  );

  assign {PCE, PCPlus4E, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, funct3E} = data_q;
  assign CtrlE = ctrl_q;

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt;
  logic [31:0] stall_cnt;

  // A bubble is either an explicit flush or a load of an empty decode slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (FlushE || (!StallE && !ValidD)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
      if (StallE && !FlushE) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign BubbleCntE = bubble_cnt;
  assign StallCntE  = stall_cnt;
`else
  assign BubbleCntE = 32'd0;
  assign StallCntE  = 32'd0;
`endif

endmodule
